// File: rtl/fmul_arbiter.sv
// Shares one pipelined float32 multiplier among NUM_REQ requesters using round-robin issue,
// and routes each product back to its owner through an in-order tag FIFO.
module fmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ-1:0][31:0] req_a_in,
  input  logic [NUM_REQ-1:0][31:0] req_b_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [31:0]              mult_a_out,
  output logic [31:0]              mult_b_out,
  output logic                     mult_v_out,
  input  logic [31:0]              mult_data_in,
  input  logic                     mult_v_in,
  output logic [31:0]              resp_data_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic                     busy_out,
  output logic                     err_out
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_REQ - 1);
  localparam logic [PTRW-1:0] PTR_LAST   = PTRW'(DEPTH - 1);
  localparam logic [PTRW:0]   FULL_COUNT = (PTRW + 1)'(DEPTH);

  logic [IDXW-1:0] lastGrant_q, lastGrant_d;
  logic [IDXW-1:0] tagMem_q [DEPTH];
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [PTRW:0]   count_q, count_d;
  logic            multV_q, multV_d;
  logic [31:0]     multA_q, multA_d;
  logic [31:0]     multB_q, multB_d;
  logic            err_q, err_d;

  logic            grantFound;
  logic [IDXW-1:0] grantIdx;
  logic            fifoFull;
  logic            pushEn;
  logic            popEn;
  logic [IDXW-1:0] headTag;

  // Round-robin search starting one past the last requester that actually transferred.
  always_comb begin
    int cand;
    cand       = 0;
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(lastGrant_q) + k) % NUM_REQ;
      if (!grantFound && req_valid_in[cand[IDXW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[IDXW-1:0];
      end
    end
  end

  assign fifoFull = (count_q == FULL_COUNT);
  assign pushEn   = grantFound && !fifoFull && !rst_in;
  assign popEn    = mult_v_in && (count_q != '0) && !rst_in;
  assign headTag  = tagMem_q[rdPtr_q];

  always_comb begin
    req_ready_out = '0;
    if (pushEn) req_ready_out[grantIdx] = 1'b1;
  end

  always_comb begin
    resp_valid_out = '0;
    if (popEn) resp_valid_out[headTag] = 1'b1;
  end

  assign resp_data_out = mult_data_in;
  assign mult_v_out    = multV_q;
  assign mult_a_out    = multA_q;
  assign mult_b_out    = multB_q;
  assign err_out       = err_q;
  assign busy_out      = (count_q != '0) | multV_q;

  // A pop in the same cycle as a push leaves the count unchanged; full is judged on the old count.
  always_comb begin
    lastGrant_d = pushEn ? grantIdx : lastGrant_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    if (pushEn) wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTRW'(1);
    if (popEn)  rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTRW'(1);
    count_d     = count_q + (PTRW + 1)'(pushEn) - (PTRW + 1)'(popEn);
    multV_d     = pushEn;
    multA_d     = pushEn ? req_a_in[grantIdx] : multA_q;
    multB_d     = pushEn ? req_b_in[grantIdx] : multB_q;
    err_d       = err_q | (mult_v_in && (count_q == '0));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lastGrant_q <= LAST_IDX;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      multV_q     <= 1'b0;
      multA_q     <= '0;
      multB_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      multV_q     <= multV_d;
      multA_q     <= multA_d;
      multB_q     <= multB_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk_in) begin
    if (pushEn) tagMem_q[wrPtr_q] <= grantIdx;
  end

  readyOneHot: assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(req_ready_out));
  respOneHot:  assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(resp_valid_out));

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model and an in-order variable-latency multiplier.
module tb_fmul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 16;

  logic                     clk_in;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0][31:0] req_a_in;
  logic [NUM_REQ-1:0][31:0] req_b_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [31:0]              mult_a_out;
  logic [31:0]              mult_b_out;
  logic                     mult_v_out;
  logic [31:0]              mult_data_in;
  logic                     mult_v_in;
  logic [31:0]              resp_data_out;
  logic [NUM_REQ-1:0]       resp_valid_out;
  logic                     busy_out;
  logic                     err_out;

  fmul_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
    .req_ready_out(req_ready_out),
    .mult_a_out(mult_a_out), .mult_b_out(mult_b_out), .mult_v_out(mult_v_out),
    .mult_data_in(mult_data_in), .mult_v_in(mult_v_in),
    .resp_data_out(resp_data_out), .resp_valid_out(resp_valid_out),
    .busy_out(busy_out), .err_out(err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks;
  int failures;

  // Reference model: owners of outstanding operations in issue order, plus the last grant.
  int          tagQ[$];
  int          lastG;
  bit          errM;
  bit          mvM;
  logic [31:0] maM;
  logic [31:0] mbM;
  int          cyc;

  function automatic void modelReset();
    tagQ.delete();
    lastG = NUM_REQ - 1;
    errM  = 1'b0;
    mvM   = 1'b0;
    maM   = '0;
    mbM   = '0;
  endfunction

  function automatic int modelGrant();
    if (rst_in || tagQ.size() >= DEPTH) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i = (lastG + k) % NUM_REQ;
      if (req_valid_in[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] expReady();
    int g = modelGrant();
    logic [NUM_REQ-1:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] expResp();
    logic [NUM_REQ-1:0] r = '0;
    if (!rst_in && mult_v_in && tagQ.size() > 0) r[tagQ[0]] = 1'b1;
    return r;
  endfunction

  function automatic bit modelBusy();
    return (tagQ.size() != 0) || mvM;
  endfunction

  // Advance one clock; the model consumes the inputs that were stable across the edge.
  task automatic tick(output int g);
    int          pre;
    bit          popping;
    logic [31:0] a;
    logic [31:0] b;
    g       = modelGrant();
    pre     = tagQ.size();
    popping = mult_v_in && (pre > 0);
    a       = (g >= 0) ? req_a_in[g] : 32'h0;
    b       = (g >= 0) ? req_b_in[g] : 32'h0;
    @(posedge clk_in);
    if (popping) void'(tagQ.pop_front());
    if (mult_v_in && pre == 0) errM = 1'b1;
    mvM = (g >= 0);
    if (g >= 0) begin
      tagQ.push_back(g);
      lastG = g;
      maM   = a;
      mbM   = b;
    end
    cyc++;
    #1;
  endtask

  task automatic setIdle();
    req_valid_in = '0;
    mult_v_in    = 1'b0;
    mult_data_in = '0;
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    setIdle();
    repeat (2) @(posedge clk_in);
    #1;
    modelReset();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst_in       = 1'b1;
    req_valid_in = '1;
    mult_v_in    = 1'b1;
    mult_data_in = 32'h1234_5678;
    @(negedge clk_in);
    checks++; if (req_ready_out !== 4'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready_out); end
    checks++; if (resp_valid_out !== 4'b0) begin failures++; $display("[TB] FAIL reset_resp_valid got=%b exp=0000", resp_valid_out); end
    checks++; if (mult_v_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_mult_v got=%b exp=0", mult_v_out); end
    checks++; if (mult_a_out !== 32'h0 || mult_b_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_operands got=%h/%h exp=0/0", mult_a_out, mult_b_out); end
    checks++; if (busy_out !== 1'b0 || err_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_err got=%b%b exp=00", busy_out, err_out); end
    @(posedge clk_in);
    #1;
    setIdle();
    modelReset();
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (err_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_err got=%b exp=0", err_out); end
    tick(g);
  endtask

  task automatic test_single_op();
    int g;
    doReset();
    req_valid_in = 4'b0001;
    req_a_in[0]  = 32'h4000_0000;
    req_b_in[0]  = 32'h4040_0000;
    @(negedge clk_in);
    checks++; if (req_ready_out !== 4'b0001) begin failures++; $display("[TB] FAIL single_ready got=%b exp=0001", req_ready_out); end
    tick(g);
    req_valid_in = '0;
    @(negedge clk_in);
    checks++; if (mult_v_out !== 1'b1) begin failures++; $display("[TB] FAIL single_issue_v got=%b exp=1", mult_v_out); end
    checks++; if (mult_a_out !== 32'h4000_0000 || mult_b_out !== 32'h4040_0000) begin failures++; $display("[TB] FAIL single_issue_ops got=%h/%h exp=40000000/40400000", mult_a_out, mult_b_out); end
    tick(g);
    @(negedge clk_in);
    checks++; if (mult_v_out !== 1'b0) begin failures++; $display("[TB] FAIL single_issue_pulse got=%b exp=0", mult_v_out); end
    checks++; if (busy_out !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", busy_out); end
    repeat (7) tick(g);
    mult_v_in    = 1'b1;
    mult_data_in = 32'h40C0_0000;
    @(negedge clk_in);
    checks++; if (resp_valid_out !== 4'b0001) begin failures++; $display("[TB] FAIL single_resp_valid got=%b exp=0001", resp_valid_out); end
    checks++; if (resp_data_out !== 32'h40C0_0000) begin failures++; $display("[TB] FAIL single_resp_data got=%h exp=40c00000", resp_data_out); end
    tick(g);
    setIdle();
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || resp_valid_out !== 4'b0) begin failures++; $display("[TB] FAIL single_done got busy=%b resp=%b exp busy=0 resp=0000", busy_out, resp_valid_out); end
    tick(g);
  endtask

  task automatic test_round_robin();
    int g;
    logic [NUM_REQ-1:0] e;
    logic [31:0] aVal [NUM_REQ];
    logic [31:0] dVal;
    doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      aVal[i]     = 32'h3F80_0000 + 32'(i);
      req_a_in[i] = aVal[i];
      req_b_in[i] = 32'h4100_0000 + 32'(i);
    end
    req_valid_in = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      e = 4'b0001 << (c % 4);
      checks++; if (req_ready_out !== e) begin failures++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready_out, e); end
      if (c > 0) begin
        checks++; if (mult_v_out !== 1'b1 || mult_a_out !== aVal[(c - 1) % 4]) begin failures++; $display("[TB] FAIL rr_issue c=%0d got v=%b a=%h exp v=1 a=%h", c, mult_v_out, mult_a_out, aVal[(c - 1) % 4]); end
      end
      tick(g);
    end
    req_valid_in = '0;
    for (int t = 0; t < 8; t++) begin
      dVal         = $urandom;
      mult_v_in    = 1'b1;
      mult_data_in = dVal;
      @(negedge clk_in);
      e = 4'b0001 << (t % 4);
      checks++; if (resp_valid_out !== e || resp_data_out !== dVal) begin failures++; $display("[TB] FAIL rr_resp t=%0d got %b/%h exp %b/%h", t, resp_valid_out, resp_data_out, e, dVal); end
      tick(g);
    end
    setIdle();
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0) begin failures++; $display("[TB] FAIL rr_drained_busy got=%b exp=0", busy_out); end
    tick(g);
  endtask

  task automatic test_full_fifo();
    int g;
    doReset();
    req_valid_in = 4'b0100;
    req_a_in[2]  = 32'h4080_0000;
    req_b_in[2]  = 32'h3F00_0000;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk_in);
      checks++; if (req_ready_out !== 4'b0100) begin failures++; $display("[TB] FAIL full_fill c=%0d got=%b exp=0100", c, req_ready_out); end
      tick(g);
    end
    @(negedge clk_in);
    checks++; if (req_ready_out !== 4'b0000) begin failures++; $display("[TB] FAIL full_stall got=%b exp=0000", req_ready_out); end
    checks++; if (int'(dut.count_q) !== DEPTH) begin failures++; $display("[TB] FAIL full_count got=%0d exp=%0d", dut.count_q, DEPTH); end
    tick(g);
    mult_v_in    = 1'b1;
    mult_data_in = 32'h4000_0000;
    @(negedge clk_in);
    checks++; if (req_ready_out !== 4'b0000) begin failures++; $display("[TB] FAIL full_pop_same_cycle got=%b exp=0000", req_ready_out); end
    checks++; if (resp_valid_out !== 4'b0100) begin failures++; $display("[TB] FAIL full_pop_resp got=%b exp=0100", resp_valid_out); end
    tick(g);
    mult_v_in = 1'b0;
    @(negedge clk_in);
    checks++; if (req_ready_out !== 4'b0100) begin failures++; $display("[TB] FAIL full_reassert got=%b exp=0100", req_ready_out); end
    tick(g);
    req_valid_in = '0;
    for (int t = 0; t < DEPTH; t++) begin
      mult_v_in    = 1'b1;
      mult_data_in = $urandom;
      @(negedge clk_in);
      checks++; if (resp_valid_out !== 4'b0100) begin failures++; $display("[TB] FAIL full_drain t=%0d got=%b exp=0100", t, resp_valid_out); end
      tick(g);
    end
    setIdle();
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || err_out !== 1'b0) begin failures++; $display("[TB] FAIL full_end got busy=%b err=%b exp 0/0", busy_out, err_out); end
    tick(g);
  endtask

  task automatic test_push_pop();
    int g;
    logic [NUM_REQ-1:0] e;
    doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_in[i] = $urandom;
      req_b_in[i] = $urandom;
    end
    req_valid_in = '1;
    repeat (5) tick(g);
    req_valid_in = 4'b0010;
    mult_v_in    = 1'b1;
    mult_data_in = 32'hC1A0_0000;
    @(negedge clk_in);
    checks++; if (int'(dut.count_q) !== 5) begin failures++; $display("[TB] FAIL pp_count_before got=%0d exp=5", dut.count_q); end
    checks++; if (req_ready_out !== 4'b0010) begin failures++; $display("[TB] FAIL pp_grant got=%b exp=0010", req_ready_out); end
    checks++; if (resp_valid_out !== 4'b0001 || resp_data_out !== 32'hC1A0_0000) begin failures++; $display("[TB] FAIL pp_oldest got %b/%h exp 0001/c1a00000", resp_valid_out, resp_data_out); end
    tick(g);
    setIdle();
    @(negedge clk_in);
    checks++; if (int'(dut.count_q) !== 5) begin failures++; $display("[TB] FAIL pp_count_after got=%0d exp=5", dut.count_q); end
    tick(g);
    for (int t = 0; t < 5; t++) begin
      mult_v_in    = 1'b1;
      mult_data_in = $urandom;
      @(negedge clk_in);
      e = expResp();
      checks++; if (resp_valid_out !== e) begin failures++; $display("[TB] FAIL pp_drain t=%0d got=%b exp=%b", t, resp_valid_out, e); end
      tick(g);
    end
    setIdle();
    tick(g);
  endtask

  task automatic test_error();
    int g;
    doReset();
    mult_v_in    = 1'b1;
    mult_data_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    checks++; if (resp_valid_out !== 4'b0) begin failures++; $display("[TB] FAIL err_no_resp got=%b exp=0000", resp_valid_out); end
    tick(g);
    mult_v_in = 1'b0;
    @(negedge clk_in);
    checks++; if (err_out !== 1'b1) begin failures++; $display("[TB] FAIL err_set got=%b exp=1", err_out); end
    req_valid_in = 4'b1000;
    req_a_in[3]  = 32'h3F80_0000;
    req_b_in[3]  = 32'h3F80_0000;
    tick(g);
    req_valid_in = '0;
    repeat (3) tick(g);
    mult_v_in    = 1'b1;
    mult_data_in = 32'h3F80_0000;
    @(negedge clk_in);
    checks++; if (resp_valid_out !== 4'b1000) begin failures++; $display("[TB] FAIL err_normal_resp got=%b exp=1000", resp_valid_out); end
    tick(g);
    mult_v_in = 1'b0;
    @(negedge clk_in);
    checks++; if (err_out !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%b exp=1", err_out); end
    doReset();
    @(negedge clk_in);
    checks++; if (err_out !== 1'b0) begin failures++; $display("[TB] FAIL err_cleared got=%b exp=0", err_out); end
    tick(g);
  endtask

  task automatic test_reset_midflight();
    int g;
    doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_in[i] = 32'h4100_0000 | 32'(i + 1);
      req_b_in[i] = 32'h4200_0000 | 32'(i + 1);
    end
    req_valid_in = '1;
    repeat (3) tick(g);
    #2;
    rst_in = 1'b1;
    #1;
    checks++; if (mult_v_out !== 1'b0 || mult_a_out !== 32'h0 || mult_b_out !== 32'h0) begin failures++; $display("[TB] FAIL mid_async_mult got v=%b a=%h b=%h exp 0/0/0", mult_v_out, mult_a_out, mult_b_out); end
    checks++; if (req_ready_out !== 4'b0 || busy_out !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_ready_busy got ready=%b busy=%b exp 0000/0", req_ready_out, busy_out); end
    checks++; if (int'(dut.count_q) !== 0) begin failures++; $display("[TB] FAIL mid_async_count got=%0d exp=0", dut.count_q); end
    modelReset();
    @(posedge clk_in);
    #1;
    setIdle();
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0) begin failures++; $display("[TB] FAIL mid_release_busy got=%b exp=0", busy_out); end
    tick(g);
    mult_v_in    = 1'b1;
    mult_data_in = 32'h4400_0000;
    @(negedge clk_in);
    checks++; if (resp_valid_out !== 4'b0) begin failures++; $display("[TB] FAIL mid_late_resp got=%b exp=0000", resp_valid_out); end
    tick(g);
    mult_v_in = 1'b0;
    @(negedge clk_in);
    checks++; if (err_out !== 1'b1) begin failures++; $display("[TB] FAIL mid_late_err got=%b exp=1", err_out); end
    doReset();
  endtask

  task automatic test_random();
    int          g;
    int          due;
    int          lastDue;
    bit          drove;
    int          dueQ[$];
    logic [31:0] valQ[$];
    logic [NUM_REQ-1:0] e;
    doReset();
    lastDue = cyc;
    for (int c = 0; c < 1400; c++) begin
      if (c >= 700 && dueQ.size() == 0 && tagQ.size() == 0 && req_valid_in == '0) break;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (c < 700 && !req_valid_in[i] && $urandom_range(0, 2) == 0) begin
          req_valid_in[i] = 1'b1;
          req_a_in[i]     = $urandom;
          req_b_in[i]     = $urandom;
        end
      end
      drove        = (dueQ.size() > 0) && (dueQ[0] <= cyc);
      mult_v_in    = drove;
      mult_data_in = drove ? valQ[0] : $urandom;
      @(negedge clk_in);
      e = expReady();
      checks++; if (req_ready_out !== e) begin failures++; $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready_out, e); end
      e = expResp();
      checks++; if (resp_valid_out !== e) begin failures++; $display("[TB] FAIL rnd_resp_valid c=%0d got=%b exp=%b", c, resp_valid_out, e); end
      if (drove) begin
        checks++; if (resp_data_out !== valQ[0]) begin failures++; $display("[TB] FAIL rnd_resp_data c=%0d got=%h exp=%h", c, resp_data_out, valQ[0]); end
      end
      checks++; if (mult_v_out !== mvM) begin failures++; $display("[TB] FAIL rnd_mult_v c=%0d got=%b exp=%b", c, mult_v_out, mvM); end
      if (mvM) begin
        checks++; if (mult_a_out !== maM || mult_b_out !== mbM) begin failures++; $display("[TB] FAIL rnd_mult_ops c=%0d got=%h/%h exp=%h/%h", c, mult_a_out, mult_b_out, maM, mbM); end
      end
      checks++; if (busy_out !== modelBusy() || err_out !== errM) begin failures++; $display("[TB] FAIL rnd_busy_err c=%0d got=%b%b exp=%b%b", c, busy_out, err_out, modelBusy(), errM); end
      tick(g);
      if (g >= 0) req_valid_in[g] = 1'b0;
      if (drove) begin
        void'(dueQ.pop_front());
        void'(valQ.pop_front());
      end
      if (mvM) begin
        due = cyc + ((c < 300) ? int'($urandom_range(1, 4)) : int'($urandom_range(8, 40)));
        if (due <= lastDue) due = lastDue + 1;
        lastDue = due;
        dueQ.push_back(due);
        valQ.push_back($urandom);
      end
    end
    setIdle();
    @(negedge clk_in);
    checks++; if (busy_out !== 1'b0 || tagQ.size() != 0) begin failures++; $display("[TB] FAIL rnd_drain got busy=%b model_outstanding=%0d exp 0/0", busy_out, tagQ.size()); end
    tick(g);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_in   = 1'b1;
    req_a_in = '0;
    req_b_in = '0;
    setIdle();
    modelReset();
    @(posedge clk_in);
    #1;
    test_reset();
    test_single_op();
    test_round_robin();
    test_full_fifo();
    test_push_pop();
    test_error();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one float32 multiplier.
REQ-002 SHALL have parameter DEPTH, default 16: capacity of the in-flight tag FIFO (power of 2), which bounds outstanding operations.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid_in, input, NUM_REQ bits: per-requester operation request.
REQ-006 SHALL have port req_a_in, input, NUM_REQ x 32 bits: float32 operand A per requester.
REQ-007 SHALL have port req_b_in, input, NUM_REQ x 32 bits: float32 operand B per requester.
REQ-008 SHALL have port req_ready_out, output, NUM_REQ bits: one-hot acceptance, combinational.
REQ-009 SHALL have port mult_a_out, output, 32 bits: operand A to the multiplier IP.
REQ-010 SHALL have port mult_b_out, output, 32 bits: operand B to the multiplier IP.
REQ-011 SHALL have port mult_v_out, output, 1 bit: operand-valid strobe to the multiplier IP.
REQ-012 SHALL have port mult_data_in, input, 32 bits: product from the multiplier IP.
REQ-013 SHALL have port mult_v_in, input, 1 bit: product-valid strobe from the multiplier IP.
REQ-014 SHALL have port resp_data_out, output, 32 bits: product, shared by all requesters.
REQ-015 SHALL have port resp_valid_out, output, NUM_REQ bits: one-hot pulse routing resp_data_out to its owner.
REQ-016 SHALL have port busy_out, output, 1 bit: high while any operation is in flight or being issued.
REQ-017 SHALL have port err_out, output, 1 bit: sticky; set on a product arriving with no outstanding tag.

Function
REQ-018 SHALL transfer an operation from requester i on a cycle where req_valid_in[i] and req_ready_out[i] are both high; the requester holds its operands until then.
REQ-019 SHALL assert at most one req_ready_out bit per cycle, and only when the FIFO count < DEPTH; a pop in the same cycle does not free a slot.
REQ-020 SHALL arbitrate round-robin: priority search starts at (last_grant+1) mod NUM_REQ and wraps; last_grant updates only on a transfer.
REQ-021 SHALL register the issue: in the cycle after a transfer, mult_v_out=1 for exactly one cycle and mult_a_out/mult_b_out carry the granted operands (latency 1).
REQ-022 SHALL allow back-to-back transfers (one per cycle) while the FIFO has room.
REQ-023 SHALL push the granted requester index into the tag FIFO at transfer time.
REQ-024 SHALL pop the FIFO head on mult_v_in=1 with count>0; in that case the same cycle's resp_data_out=mult_data_in and resp_valid_out[head]=1, both combinational.
REQ-025 SHALL handle a simultaneous push and pop with the count unchanged and both operations taking effect.
REQ-026 SHALL handle mult_v_in=1 with count=0 as follows: no resp_valid_out, product dropped, err_out set until reset.
REQ-027 SHALL tolerate any multiplier latency, including variable latency, provided the IP returns products in order.
REQ-028 SHALL compute busy_out = (count != 0) | mult_v_out.
REQ-029 SHALL keep resp_valid_out low in cycles without a pop; resp_data_out is don't-care then.
REQ-030 SHALL wrap the FIFO read and write pointers modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-031 SHALL, while rst_in=1 and asynchronously, force: mult_v_out=0, mult_a_out=0, mult_b_out=0, err_out=0, FIFO empty (pointers and count 0), and last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-032 SHALL drive req_ready_out=0 and resp_valid_out=0 during reset.
REQ-033 SHALL, on reset mid-operation, discard in-flight tags; products arriving after reset release with count 0 set err_out per REQ-026.

Verification
REQ-034 SHALL verify single op: req0 with A=0x40000000, B=0x40400000 -> ready0 the same cycle, mult_v_out the next cycle with those operands; a model returns 0x40C00000 after 8 cycles -> resp_valid_out=0001, resp_data_out=0x40C00000.
REQ-035 SHALL verify round-robin: all 4 requesters held valid from reset -> grant order 0,1,2,3,0,... on consecutive cycles, with no gaps.
REQ-036 SHALL verify full FIFO: with DEPTH=16, 16 issues and no products -> req_ready_out=0 on cycle 17; one product returned -> ready reasserts the cycle after the pop.
REQ-037 SHALL verify simultaneous push and pop with count=5 -> count stays 5, and the response is routed to the oldest tag.
REQ-038 SHALL verify the error path: mult_v_in=1 with count=0 -> no resp_valid_out and err_out=1, which persists until rst_in.
REQ-039 SHALL verify reset mid-flight: rst_in asserted with 3 ops outstanding -> outputs reset immediately without a clock edge, and busy_out=0 after release.
